// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the I/D memory arbiter
// Purpose: state encoding, default widths and port-select codes used by
//          mem_arbiter and rr_arb2.
// Ports:   none (package).
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    // Port-select codes; the last-served pointer uses the same encoding.
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
// Purpose: chooses between the I port (req[0]) and the D port (req[1]).
//          On a tie the port that was not served last wins.
// Ports:   req  - request vector {D, I}
//          last - port served most recently (SEL_I / SEL_D)
//          sel  - chosen port (SEL_I / SEL_D); SEL_I when nobody requests
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel
);

    always_comb begin
        sel = SEL_I;
        case (req)
            2'b01:   sel = SEL_I;
            2'b10:   sel = SEL_D;
            2'b11:   sel = (last == SEL_I) ? SEL_D : SEL_I;
            default: sel = SEL_I;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one slow memory between I- and D-cache
// Purpose: grants the memory to one cache at a time, holds the grant until
//          mem_ready, then inserts one DONE bubble before re-arbitrating.
// Ports:   clk, rst_n (async, active-low)
//          i_read/i_write/i_addr/i_wdata -> i_rdata/i_ready   I-cache port
//          d_read/d_write/d_addr/d_wdata -> d_rdata/d_ready   D-cache port
//          mem_read/mem_write/mem_addr/mem_wdata, mem_rdata/mem_ready  memory side
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state;
    logic              last;
    logic              pick;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

    rr_arb2 u_rr (
        .req  ({d_read | d_write, i_read | i_write}),
        .last (last),
        .sel  (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= SEL_I;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_read | i_write | d_read | d_write)
                        state <= (pick == SEL_D) ? GNT_D : GNT_I;
                end
                GNT_I: begin
                    // Keep a copy so mem_addr/mem_wdata stay put outside the grant.
                    hold_addr  <= i_addr;
                    hold_wdata <= i_wdata;
                    if (mem_ready) begin
                        last  <= SEL_I;
                        state <= DONE;
                    end
                end
                GNT_D: begin
                    hold_addr  <= d_addr;
                    hold_wdata <= d_wdata;
                    if (mem_ready) begin
                        last  <= SEL_D;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mux selects come only from the registered state; the request strobes
    // reach mem_* solely as data through the selected leg.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = hold_addr;
        mem_wdata = hold_wdata;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state)
            GNT_I: begin
                mem_read  = i_read;
                mem_write = i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_ready   = mem_ready;
            end
            GNT_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_read = 1'b0, i_write = 1'b0;
    logic [27:0]  i_addr = '0;
    logic [127:0] i_wdata = '0;
    logic [127:0] i_rdata;
    logic         i_ready;
    logic         d_read = 1'b0, d_write = 1'b0;
    logic [27:0]  d_addr = '0;
    logic [127:0] d_wdata = '0;
    logic [127:0] d_rdata;
    logic         d_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};

    mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task clear_inputs;
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task do_reset;
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({mem_read, mem_write, i_ready, d_ready, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_in: strobes/readies=%b addr=%h wdata=%h want all 0",
                     {mem_read, mem_write, i_ready, d_ready}, mem_addr, mem_wdata);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        #1;
        n_chk++;
        if ({mem_read, mem_write, i_ready, d_ready, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_out: strobes/readies=%b addr=%h wdata=%h want all 0",
                     {mem_read, mem_write, i_ready, d_ready}, mem_addr, mem_wdata);
        else n_pass++;
    endtask

    task test_lone_read;
        do_reset();
        @(negedge clk);
        i_read = 1; i_addr = 28'h0000010;
        #1;
        n_chk++;
        if (mem_read !== 1'b0) $display("FAIL lone_idle: mem_read=%b want 0", mem_read);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_ready = (k == 4);
            #1;
            n_chk++;
            if ({mem_read, mem_write, i_ready, d_ready} !== {1'b1, 1'b0, (k == 4), 1'b0})
                $display("FAIL lone_wait%0d: rd/wr/ir/dr=%b want %b", k,
                         {mem_read, mem_write, i_ready, d_ready}, {1'b1, 1'b0, (k == 4), 1'b0});
            else n_pass++;
            n_chk++;
            if (mem_addr !== 28'h0000010) $display("FAIL lone_addr%0d: %h want 0000010", k, mem_addr);
            else n_pass++;
        end
        @(negedge clk);
        i_read = 0; mem_ready = 0;
        #1;
        n_chk++;
        if (mem_read !== 1'b0 || mem_addr !== 28'h0000010)
            $display("FAIL lone_done: mem_read=%b addr=%h want 0/0000010", mem_read, mem_addr);
        else n_pass++;
    endtask

    task test_tie;
        do_reset();
        @(negedge clk);
        i_read = 1; i_addr = 28'h0000AAA;
        d_read = 1; d_addr = 28'h0000BBB;
        #1;
        @(negedge clk);
        mem_ready = 1;
        #1;
        n_chk++;
        if (mem_addr !== 28'h0000BBB || d_ready !== 1'b1 || i_ready !== 1'b0)
            $display("FAIL tie_first_d: addr=%h dr=%b ir=%b want 0000bbb/1/0", mem_addr, d_ready, i_ready);
        else n_pass++;
        @(negedge clk);
        mem_ready = 0; d_addr = 28'h0000CCC;  // D re-requests at once -> second tie
        #1;
        @(negedge clk);
        #1;
        n_chk++;
        if (mem_read !== 1'b0) $display("FAIL tie_bubble: mem_read=%b want 0", mem_read);
        else n_pass++;
        @(negedge clk);
        mem_ready = 1;
        #1;
        n_chk++;
        if (mem_addr !== 28'h0000AAA || i_ready !== 1'b1 || d_ready !== 1'b0)
            $display("FAIL tie_repeat_i: addr=%h ir=%b dr=%b want 0000aaa/1/0", mem_addr, i_ready, d_ready);
        else n_pass++;
        @(negedge clk);
        mem_ready = 0; i_read = 0;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1;
        #1;
        n_chk++;
        if (mem_addr !== 28'h0000CCC || d_ready !== 1'b1)
            $display("FAIL tie_d_again: addr=%h dr=%b want 0000ccc/1", mem_addr, d_ready);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task test_wait;
        do_reset();
        @(negedge clk);
        i_read = 1; i_addr = 28'h0000100; i_wdata = {4{32'h1234_5678}};
        @(negedge clk);
        d_write = 1; d_addr = 28'h0000200; d_wdata = PAT_A5;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            mem_ready = (k == 2);
            #1;
            n_chk++;
            if (mem_write !== 1'b0 || mem_wdata !== {4{32'h1234_5678}} || i_ready !== (k == 2) || d_ready !== 1'b0)
                $display("FAIL wait_i%0d: wr=%b wdata=%h ir=%b dr=%b", k, mem_write, mem_wdata, i_ready, d_ready);
            else n_pass++;
        end
        @(negedge clk);
        mem_ready = 0; i_read = 0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_chk++;
            if (mem_write !== 1'b0) $display("FAIL wait_gap%0d: mem_write=%b want 0", k, mem_write);
            else n_pass++;
        end
        @(negedge clk);
        mem_ready = 1;
        #1;
        n_chk++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== PAT_A5 ||
            mem_addr !== 28'h0000200 || d_ready !== 1'b1)
            $display("FAIL wait_d: wr=%b rd=%b wdata=%h addr=%h dr=%b want 1/0/a5../0000200/1",
                     mem_write, mem_read, mem_wdata, mem_addr, d_ready);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task test_spurious;
        do_reset();
        @(negedge clk);
        mem_ready = 1;
        #1;
        n_chk++;
        if ({i_ready, d_ready, mem_read, mem_write} !== 4'b0)
            $display("FAIL spur_ready: ir/dr/rd/wr=%b want 0000", {i_ready, d_ready, mem_read, mem_write});
        else n_pass++;
        @(negedge clk);
        mem_ready = 0; i_read = 1; i_addr = 28'h0000033;
        #1;
        n_chk++;
        if (mem_read !== 1'b0) $display("FAIL spur_idle: mem_read=%b want 0", mem_read);
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000033)
            $display("FAIL spur_grant: mem_read=%b addr=%h want 1/0000033", mem_read, mem_addr);
        else n_pass++;
        @(negedge clk);
        mem_ready = 1;
        @(negedge clk);
        clear_inputs();
    endtask

    task test_reset_mid;
        do_reset();
        @(negedge clk);
        d_read = 1; d_addr = 28'h0000444; d_wdata = PAT_A5;
        @(negedge clk);
        #1;
        n_chk++;
        if (mem_read !== 1'b1) $display("FAIL rmid_grant: mem_read=%b want 1", mem_read);
        else n_pass++;
        @(negedge clk);
        #2;
        rst_n = 0; mem_ready = 1;
        #1;
        n_chk++;
        if ({mem_read, mem_write, i_ready, d_ready, mem_addr, mem_wdata} !== '0)
            $display("FAIL rmid_zero: rd/wr/ir/dr=%b addr=%h wdata=%h want all 0",
                     {mem_read, mem_write, i_ready, d_ready}, mem_addr, mem_wdata);
        else n_pass++;
        @(negedge clk);
        d_read = 0; mem_ready = 0;
        @(negedge clk);
        rst_n = 1;
        d_read = 1; d_addr = 28'h0000555;
        #1;
        n_chk++;
        if (mem_read !== 1'b0 || d_ready !== 1'b0 || mem_addr !== 28'h0)
            $display("FAIL rmid_idle: rd=%b dr=%b addr=%h want 0/0/0", mem_read, d_ready, mem_addr);
        else n_pass++;
        @(negedge clk);
        mem_ready = 1;
        #1;
        n_chk++;
        if (mem_addr !== 28'h0000555 || d_ready !== 1'b1)
            $display("FAIL rmid_after: addr=%h dr=%b want 0000555/1", mem_addr, d_ready);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task test_back_to_back;
        logic exp_d, exp_i;
        do_reset();
        // Memory answers immediately and holds mem_ready high throughout; outside
        // a grant that pulse must be ignored.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            d_read = 1; d_addr = 28'h0000777; mem_ready = 1;
            if (c == 4) begin i_read = 1; i_addr = 28'h0000888; end
            if (c == 8) i_read = 0;
            #1;
            exp_d = (c == 1) || (c == 4) || (c == 10);
            exp_i = (c == 7);
            n_chk++;
            if (d_ready !== exp_d || i_ready !== exp_i)
                $display("FAIL b2b_c%0d: dr=%b ir=%b want %b/%b", c, d_ready, i_ready, exp_d, exp_i);
            else n_pass++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task test_random;
        int m_owner, m_last;
        bit m_bubble, i_pend, d_pend;
        logic [27:0]  m_addr, e_addr;
        logic [127:0] m_wdata, e_wd;
        logic e_rd, e_wr, e_ir, e_dr;
        logic [1:0] rw;
        do_reset();
        m_owner = 0; m_last = 1; m_bubble = 0; i_pend = 0; d_pend = 0;
        m_addr = '0; m_wdata = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!i_pend && $urandom_range(1) == 1) begin
                i_pend = 1;
                rw = 2'($urandom_range(1, 3));
                i_read = rw[0]; i_write = rw[1];
                i_addr = 28'($urandom);
                i_wdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (!i_pend) begin
                i_read = 0; i_write = 0; i_addr = 28'($urandom);
            end
            if (!d_pend && $urandom_range(1) == 1) begin
                d_pend = 1;
                rw = 2'($urandom_range(1, 3));
                d_read = rw[0]; d_write = rw[1];
                d_addr = 28'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (!d_pend) begin
                d_read = 0; d_write = 0; d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_ready = (m_owner != 0) ? ($urandom_range(2) == 0) : ($urandom_range(3) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_addr = m_addr; e_wd = m_wdata;
            if (m_owner == 1) begin
                e_rd = i_read; e_wr = i_write; e_addr = i_addr; e_wd = i_wdata; e_ir = mem_ready;
            end else if (m_owner == 2) begin
                e_rd = d_read; e_wr = d_write; e_addr = d_addr; e_wd = d_wdata; e_dr = mem_ready;
            end
            n_chk++;
            if ({mem_read, mem_write, i_ready, d_ready} !== {e_rd, e_wr, e_ir, e_dr})
                $display("FAIL rnd_ctl c%0d: rd/wr/ir/dr=%b want %b", c,
                         {mem_read, mem_write, i_ready, d_ready}, {e_rd, e_wr, e_ir, e_dr});
            else n_pass++;
            n_chk++;
            if (mem_addr !== e_addr || mem_wdata !== e_wd)
                $display("FAIL rnd_data c%0d: addr=%h wdata=%h want %h/%h", c, mem_addr, mem_wdata, e_addr, e_wd);
            else n_pass++;
            n_chk++;
            if (i_rdata !== mem_rdata || d_rdata !== mem_rdata)
                $display("FAIL rnd_rdata c%0d: i=%h d=%h want %h", c, i_rdata, d_rdata, mem_rdata);
            else n_pass++;
            // Advance the reference: a grant lasts until memory answers, then
            // one quiet cycle, then the next pick alternates on ties.
            if (m_owner != 0) begin
                m_addr = e_addr; m_wdata = e_wd;
                if (mem_ready) begin m_last = m_owner; m_owner = 0; m_bubble = 1; end
            end else if (m_bubble) begin
                m_bubble = 0;
            end else if ((i_read | i_write) && (d_read | d_write)) begin
                m_owner = (m_last == 1) ? 2 : 1;
            end else if (i_read | i_write) begin
                m_owner = 1;
            end else if (d_read | d_write) begin
                m_owner = 2;
            end
            if (e_ir) i_pend = 0;
            if (e_dr) d_pend = 0;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_lone_read();
        test_tie();
        test_wait();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
